// File: rtl/ldpc_pkg.sv
// Shared types and widths for the LDPC encoder scheduler.
// Message, codeword and UART byte widths plus FSM state encoding.
package ldpc_pkg;

    localparam int MSG_W  = 4;
    localparam int CODE_W = 12;
    localparam int BYTE_W = 8;

    typedef enum logic [3:0] {
        S_IDLE,
        S_POP,
        S_ENC_REQ,
        S_ENC_WAIT,
        S_TX_HI,
        S_TX_HI_WAIT,
        S_TX_LO,
        S_TX_LO_WAIT,
        S_NEXT
    } state_t;

endpackage

// File: rtl/ldpc_byte_fifo.sv
// Synchronous byte FIFO for received UART data.
// Head byte is registered on pop; a push into a full FIFO drops.
module ldpc_byte_fifo
    import ldpc_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    push_i,
    input  logic [BYTE_W-1:0]       data_i,
    input  logic                    pop_i,
    output logic [BYTE_W-1:0]       data_o,
    output logic [$clog2(DEPTH):0]  level_o,
    output logic                    empty_o,
    output logic                    drop_o
);

    localparam int AW = $clog2(DEPTH);

    logic [BYTE_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wptr_q, wptr_d;
    logic [AW-1:0]     rptr_q, rptr_d;
    logic [AW:0]       lvl_q, lvl_d;
    logic [BYTE_W-1:0] dout_q, dout_d;
    logic              full;
    logic              rd;
    logic              wr;

    assign full    = (lvl_q == (AW+1)'(DEPTH));
    assign empty_o = (lvl_q == '0);
    // A pop frees the head slot first, so a full FIFO still accepts.
    assign rd      = pop_i && !empty_o;
    assign wr      = push_i && (!full || rd);
    assign drop_o  = push_i && !wr;
    assign data_o  = dout_q;
    assign level_o = lvl_q;

    // Next-state for pointers, level and registered head byte.
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        dout_d = dout_q;
        lvl_d  = lvl_q + (AW+1)'(wr) - (AW+1)'(rd);
        if (wr) wptr_d = wptr_q + AW'(1);
        if (rd) begin
            rptr_d = rptr_q + AW'(1);
            dout_d = mem_q[rptr_q];
        end
    end

    // Storage array, written only on an accepted push.
    always_ff @(posedge clk_i) begin
        if (wr) mem_q[wptr_q] <= data_i;
    end

    // Pointer, level and head-byte registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            lvl_q  <= '0;
            dout_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            lvl_q  <= lvl_d;
            dout_q <= dout_d;
        end
    end

endmodule

// File: rtl/ldpc_enc_scheduler.sv
// Sequences rx bytes through the 4->12 encoder to the UART tx.
// Each byte yields two nibbles, low first, each sent as two bytes.
module ldpc_enc_scheduler
    import ldpc_pkg::*;
#(
    parameter int FIFO_DEPTH  = 8,
    parameter int ENC_TIMEOUT = 64,
    parameter int GUARD_CYC   = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         rx_valid,
    input  logic [BYTE_W-1:0]            rx_data,
    output logic [MSG_W-1:0]             enc_msg,
    output logic                         enc_start,
    input  logic                         enc_done,
    input  logic [CODE_W-1:0]            enc_code,
    output logic                         tx_en,
    output logic [BYTE_W-1:0]            tx_data,
    input  logic                         tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
    output logic                         err_overflow,
    output logic                         err_timeout,
    output logic                         idle
);

    localparam int TW = $clog2(ENC_TIMEOUT + 1);
    localparam int GW = $clog2(GUARD_CYC + 2);
    localparam int HW = CODE_W - BYTE_W;

    state_t            state_q, state_d;
    logic              nib_q, nib_d;
    logic [BYTE_W-1:0] code_q, code_d;
    logic [BYTE_W-1:0] tx_q, tx_d;
    logic [TW-1:0]     tmo_q, tmo_d;
    logic [GW-1:0]     grd_q, grd_d;
    logic              eovf_q, eovf_d;
    logic              etmo_q, etmo_d;

    logic [BYTE_W-1:0] byte_w;
    logic              f_empty;
    logic              f_drop;
    logic              pop;

    ldpc_byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_i   (rst),
        .push_i  (rx_valid),
        .data_i  (rx_data),
        .pop_i   (pop),
        .data_o  (byte_w),
        .level_o (fifo_level),
        .empty_o (f_empty),
        .drop_o  (f_drop)
    );

    assign enc_msg      = nib_q ? byte_w[7:4] : byte_w[3:0];
    assign tx_data      = tx_q;
    assign err_overflow = eovf_q;
    assign err_timeout  = etmo_q;
    assign idle         = (state_q == S_IDLE) && f_empty;

    // Next-state and strobes for the nibble/byte sequencer.
    always_comb begin
        state_d   = state_q;
        nib_d     = nib_q;
        code_d    = code_q;
        tx_d      = tx_q;
        tmo_d     = tmo_q;
        grd_d     = grd_q;
        eovf_d    = eovf_q | f_drop;
        etmo_d    = etmo_q;
        enc_start = 1'b0;
        tx_en     = 1'b0;
        pop       = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (!f_empty) state_d = S_POP;
            end
            S_POP: begin
                pop     = 1'b1;
                nib_d   = 1'b0;
                state_d = S_ENC_REQ;
            end
            S_ENC_REQ: begin
                enc_start = 1'b1;
                tmo_d     = '0;
                state_d   = S_ENC_WAIT;
            end
            S_ENC_WAIT: begin
                if (enc_done) begin
                    code_d  = enc_code[BYTE_W-1:0];
                    tx_d    = {{(BYTE_W-HW){1'b0}},
                               enc_code[CODE_W-1:BYTE_W]};
                    state_d = S_TX_HI;
                end else if (tmo_q == TW'(ENC_TIMEOUT - 1)) begin
                    etmo_d  = 1'b1;
                    state_d = S_NEXT;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            S_TX_HI: begin
                if (!tx_busy) begin
                    tx_en   = 1'b1;
                    grd_d   = '0;
                    state_d = S_TX_HI_WAIT;
                end
            end
            S_TX_HI_WAIT: begin
                // busy may lag tx_en, so it is not trusted at first
                if (grd_q != GW'(GUARD_CYC)) begin
                    grd_d = grd_q + GW'(1);
                end else if (!tx_busy) begin
                    tx_d    = code_q;
                    state_d = S_TX_LO;
                end
            end
            S_TX_LO: begin
                if (!tx_busy) begin
                    tx_en   = 1'b1;
                    grd_d   = '0;
                    state_d = S_TX_LO_WAIT;
                end
            end
            S_TX_LO_WAIT: begin
                if (grd_q != GW'(GUARD_CYC)) begin
                    grd_d = grd_q + GW'(1);
                end else if (!tx_busy) begin
                    state_d = S_NEXT;
                end
            end
            S_NEXT: begin
                if (!nib_q) begin
                    nib_d   = 1'b1;
                    state_d = S_ENC_REQ;
                end else if (!f_empty) begin
                    state_d = S_POP;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Sequencer registers; reset drops any in-flight work.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            nib_q   <= 1'b0;
            code_q  <= '0;
            tx_q    <= '0;
            tmo_q   <= '0;
            grd_q   <= '0;
            eovf_q  <= 1'b0;
            etmo_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            nib_q   <= nib_d;
            code_q  <= code_d;
            tx_q    <= tx_d;
            tmo_q   <= tmo_d;
            grd_q   <= grd_d;
            eovf_q  <= eovf_d;
            etmo_q  <= etmo_d;
        end
    end

endmodule

// File: tb/tb_ldpc_enc_scheduler.sv
// Directed bench for ldpc_enc_scheduler with encoder and UART tx models.
// Models act on the falling edge; the test drives 1 unit after it.
module tb_ldpc_enc_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic [3:0]  enc_msg;
    logic        enc_start;
    logic        enc_done = 1'b0;
    logic [11:0] enc_code = 12'h000;
    logic        tx_en;
    logic [7:0]  tx_data;
    logic        tx_busy = 1'b0;
    logic [3:0]  fifo_level;
    logic        err_overflow;
    logic        err_timeout;
    logic        idle;

    int errors = 0;
    int checks = 0;

    // encoder model state
    int         ecnt = 0;
    logic [3:0] epend = 4'h0;
    logic       emute = 1'b0;
    logic [3:0] emute_msg = 4'h0;
    int         stray_req = 0;
    int         stray_ack = 0;
    int         enc_viol = 0;
    logic [7:0] msgq [$];

    // transmitter model state
    int         blen = 0;
    logic       thold = 1'b0;
    int         bcnt = 0;
    logic       arm = 1'b0;
    logic [7:0] last_tx = 8'h00;
    int         tx_viol = 0;
    logic [7:0] txq [$];

    typedef struct packed {
        logic [7:0]  rx;
        logic [31:0] tx;
        logic [7:0]  m;
    } vec_t;

    vec_t vt [5];

    ldpc_enc_scheduler dut (
        .clk          (clk),
        .rst          (rst),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .enc_msg      (enc_msg),
        .enc_start    (enc_start),
        .enc_done     (enc_done),
        .enc_code     (enc_code),
        .tx_en        (tx_en),
        .tx_data      (tx_data),
        .tx_busy      (tx_busy),
        .fifo_level   (fifo_level),
        .err_overflow (err_overflow),
        .err_timeout  (err_timeout),
        .idle         (idle)
    );

    always #5 clk = ~clk;

    // Encoder: answers {msg,8'h5A} three cycles after enc_start.
    always @(negedge clk) begin
        enc_done = 1'b0;
        if (rst) begin
            ecnt = 0;
        end else if (ecnt > 0) begin
            if (enc_msg !== epend) enc_viol++;
            ecnt--;
            if (ecnt == 0) begin
                enc_done = 1'b1;
                enc_code = {epend, 8'h5A};
            end
        end
        if (stray_req != stray_ack) begin
            stray_ack = stray_req;
            enc_done  = 1'b1;
            enc_code  = 12'hFFF;
        end
        if (!rst && enc_start) begin
            msgq.push_back({4'h0, enc_msg});
            if (!(emute && enc_msg == emute_msg)) begin
                epend = enc_msg;
                ecnt  = 3;
            end
        end
    end

    // Transmitter: busy rises a cycle after tx_en for blen cycles.
    always @(negedge clk) begin
        if (rst) begin
            bcnt = 0;
            arm  = 1'b0;
        end else begin
            if (tx_busy && tx_data !== last_tx) tx_viol++;
            if (tx_en) begin
                if (tx_busy) tx_viol++;
                txq.push_back(tx_data);
                last_tx = tx_data;
                arm = 1'b1;
            end else if (arm) begin
                arm  = 1'b0;
                bcnt = blen;
            end else if (bcnt > 0) begin
                bcnt--;
            end
        end
        tx_busy = thold || (bcnt > 0);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        rx_valid = 1'b0;
        thold    = 1'b0;
        emute    = 1'b0;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic send(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        step();
        rx_valid = 1'b0;
    endtask

    task automatic wait_done(input int ntx, input int limit,
                             input string nm);
        int k = 0;
        while (!(txq.size() >= ntx && idle) && k < limit) begin
            step();
            k++;
        end
        chk({"done_", nm}, 32'(k < limit), 1);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_enc_start"}, enc_start, 0);
        chk({tag, "_tx_en"}, tx_en, 0);
        chk({tag, "_enc_msg"}, enc_msg, 0);
        chk({tag, "_tx_data"}, tx_data, 0);
        chk({tag, "_idle"}, idle, 1);
        chk({tag, "_level"}, fifo_level, 0);
        chk({tag, "_ovf"}, err_overflow, 0);
        chk({tag, "_tmo"}, err_timeout, 0);
    endtask

    initial begin
        int base;
        int mbase;
        int k;
        logic [7:0]  b;
        logic [31:0] t;

        vt[0] = '{8'hA3, 32'h035A0A5A, 8'h3A};
        vt[1] = '{8'h00, 32'h005A005A, 8'h00};
        vt[2] = '{8'hFF, 32'h0F5A0F5A, 8'hFF};
        vt[3] = '{8'h5C, 32'h0C5A055A, 8'hC5};
        vt[4] = '{8'h81, 32'h015A085A, 8'h18};

        // reset state
        do_reset();
        chk_reset("rst0");

        // latency: write, POP, then enc_start on the third cycle
        blen = 3;
        send(8'h3C);
        chk("lat_c1_level", fifo_level, 1);
        chk("lat_c1_start", enc_start, 0);
        step();
        chk("lat_c2_start", enc_start, 0);
        step();
        chk("lat_c3_start", enc_start, 1);
        chk("lat_c3_msg", enc_msg, 4'hC);
        chk("lat_c3_level", fifo_level, 0);
        wait_done(txq.size() + 4, 300, "lat");

        // table of single bytes
        for (int i = 0; i < 5; i++) begin
            base  = txq.size();
            mbase = msgq.size();
            send(vt[i].rx);
            wait_done(base + 4, 300, $sformatf("v%0d", i));
            t = vt[i].tx;
            for (int j = 0; j < 4; j++)
                chk($sformatf("v%0d_tx%0d", i, j),
                    txq[base + j], t[31 - 8*j -: 8]);
            chk($sformatf("v%0d_m0", i), msgq[mbase], {4'h0, vt[i].m[7:4]});
            chk($sformatf("v%0d_m1", i), msgq[mbase + 1], {4'h0, vt[i].m[3:0]});
            chk($sformatf("v%0d_idle", i), idle, 1);
        end

        // encoder timeout on nibble 5; nibble 7 still goes out
        do_reset();
        blen      = 2;
        emute     = 1'b1;
        emute_msg = 4'h5;
        base      = txq.size();
        mbase     = msgq.size();
        send(8'h75);
        k = 0;
        while (!enc_start && k < 10) begin
            step();
            k++;
        end
        chk("tmo_start_seen", 32'(k < 10), 1);
        chk("tmo_msg", enc_msg, 4'h5);
        repeat (60) step();
        chk("tmo_not_yet", err_timeout, 0);
        wait_done(base + 2, 300, "tmo");
        chk("tmo_flag", err_timeout, 1);
        chk("tmo_count", txq.size() - base, 2);
        chk("tmo_tx0", txq[base], 8'h07);
        chk("tmo_tx1", txq[base + 1], 8'h5A);
        chk("tmo_m1", msgq[mbase + 1], 8'h07);

        // ten bytes back to back, slow transmitter. The first byte
        // leaves the FIFO at POP before it fills, so only the tenth
        // byte finds it full and is dropped.
        do_reset();
        emute = 1'b0;
        blen  = 20;
        base  = txq.size();
        for (int i = 0; i < 10; i++) begin
            b = {4'(i), 4'(9 - i)};
            send(b);
        end
        chk("ovf_flag", err_overflow, 1);
        chk("ovf_level", fifo_level, 8);
        wait_done(base + 36, 4000, "ovf");
        chk("ovf_count", txq.size() - base, 36);
        for (int i = 0; i < 9; i++) begin
            b = {4'(i), 4'(9 - i)};
            chk($sformatf("ovf_b%0d_0", i), txq[base + 4*i], {4'h0, b[3:0]});
            chk($sformatf("ovf_b%0d_1", i), txq[base + 4*i + 1], 8'h5A);
            chk($sformatf("ovf_b%0d_2", i), txq[base + 4*i + 2], {4'h0, b[7:4]});
            chk($sformatf("ovf_b%0d_3", i), txq[base + 4*i + 3], 8'h5A);
        end
        chk("ovf_sticky", err_overflow, 1);

        // write coincident with POP on a full FIFO
        do_reset();
        blen = 0;
        base = txq.size();
        for (int i = 0; i < 9; i++) send(8'hA0 + 8'(i));
        k = 0;
        while (txq.size() < base + 4 && k < 300) begin
            step();
            k++;
        end
        chk("coin_first_byte", 32'(k < 300), 1);
        thold = 1'b1;
        repeat (5) step();
        chk("coin_full", fifo_level, 8);
        thold = 1'b0;
        repeat (3) step();
        send(8'h5E);
        chk("coin_ovf", err_overflow, 0);
        chk("coin_level", fifo_level, 8);
        chk("coin_enc_start", enc_start, 1);
        wait_done(base + 40, 2000, "coin");
        chk("coin_count", txq.size() - base, 40);
        chk("coin_last0", txq[base + 36], 8'h0E);
        chk("coin_last2", txq[base + 38], 8'h05);
        chk("coin_ovf_end", err_overflow, 0);

        // reset while waiting on the low byte with 3 bytes queued
        do_reset();
        blen  = 30;
        base  = txq.size();
        mbase = msgq.size();
        send(8'h11);
        send(8'h22);
        send(8'h33);
        send(8'h44);
        k = 0;
        while (txq.size() < base + 2 && k < 300) begin
            step();
            k++;
        end
        chk("mid_reached", 32'(k < 300), 1);
        chk("mid_level", fifo_level, 3);
        rst = 1'b1;
        step();
        chk_reset("mid");
        rst = 1'b0;
        step();
        stray_req++;
        repeat (20) step();
        chk("mid_no_tx", txq.size() - base, 2);
        chk("mid_no_enc", msgq.size() - mbase, 1);
        chk("mid_idle", idle, 1);

        chk("enc_msg_stable", enc_viol, 0);
        chk("tx_protocol", tx_viol, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
